// File: rtl/ffa_postproc_hs_if.sv
// rtl/ffa_postproc_hs_if.sv - handshake and data bundle for the FFA recombination stage
interface ffa_postproc_hs_if #(
   parameter int DWIDTH  = 16,
   parameter int DDWIDTH = 2 * DWIDTH
);
   logic                       req_in;
   logic                       ack_in;
   logic signed [0:DWIDTH-1]   data_in_h0;
   logic signed [0:DWIDTH-1]   data_in_h1;
   logic signed [0:DWIDTH-1]   data_in_h01;
   logic                       req_out;
   logic                       ack_out;
   logic signed [0:DDWIDTH-1]  data_out;
   logic                       sat_flag;

   // producer/consumer side
   modport master (
      output req_in, data_in_h0, data_in_h1, data_in_h01, req_out,
      input  ack_in, ack_out, data_out, sat_flag
   );

   // recombination stage side
   modport slave (
      input  req_in, data_in_h0, data_in_h1, data_in_h01, req_out,
      output ack_in, ack_out, data_out, sat_flag
   );
endinterface

// File: rtl/ffa_postproc_hs.sv
// rtl/ffa_postproc_hs.sv - 2-parallel FFA recombination with four-phase in/out handshakes
module ffa_postproc_hs #(
   parameter int NR_STAGES = 32,
   parameter int DWIDTH    = 16,
   parameter int DDWIDTH   = 2 * DWIDTH
) (
   input  logic               clk,
   input  logic               rst,
   ffa_postproc_hs_if.slave   bus
);
   localparam int EW = DWIDTH + 2;
   localparam logic signed [EW-1:0] MAX_E = EW'((2 ** (DWIDTH - 1)) - 1);
   localparam logic signed [EW-1:0] MIN_E = ~MAX_E;

   // The 2-parallel split needs an even tap count and an exact pair width.
   if ((NR_STAGES % 2) != 0) begin : g_bad_taps
      $error("ffa_postproc_hs: NR_STAGES must be even");
   end
   if (DDWIDTH != 2 * DWIDTH) begin : g_bad_width
      $error("ffa_postproc_hs: DDWIDTH must be 2*DWIDTH");
   end

   typedef enum logic [1:0] {S_IDLE, S_IN_ACK, S_OUT_WAIT, S_OUT_ACK} state_t;

   state_t                     state, state_nx;
   logic signed [0:DWIDTH-1]   d1;
   logic signed [0:DDWIDTH-1]  result;

   logic signed [EW-1:0] p0_x, p1_x, p01_x, d1_x, y0_w, y1_w;
   logic                 y0_clamp, y1_clamp;
   logic                 accept_in, launch_out;

   function automatic logic signed [0:DWIDTH-1] sat(input logic signed [EW-1:0] v);
      if (v > MAX_E)      return MAX_E[DWIDTH-1:0];
      else if (v < MIN_E) return MIN_E[DWIDTH-1:0];
      else                return v[DWIDTH-1:0];
   endfunction

   // Sign-extend operands (index 0 is the sign bit) and form both output phases.
   always_comb begin
      p0_x     = {{2{bus.data_in_h0[0]}},  bus.data_in_h0};
      p1_x     = {{2{bus.data_in_h1[0]}},  bus.data_in_h1};
      p01_x    = {{2{bus.data_in_h01[0]}}, bus.data_in_h01};
      d1_x     = {{2{d1[0]}}, d1};
      y0_w     = p0_x + d1_x;
      y1_w     = p01_x - p0_x - p1_x;
      y0_clamp = (y0_w > MAX_E) || (y0_w < MIN_E);
      y1_clamp = (y1_w > MAX_E) || (y1_w < MIN_E);
   end

   // State register; reset drops any in-flight pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state decode; a single result register means input stalls until the pair leaves.
   always_comb begin
      state_nx   = state;
      accept_in  = 1'b0;
      launch_out = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.req_in) begin
               accept_in = 1'b1;
               state_nx  = S_IN_ACK;
            end
         end
         S_IN_ACK: begin
            if (!bus.req_in) state_nx = S_OUT_WAIT;
         end
         S_OUT_WAIT: begin
            if (bus.req_out) begin
               launch_out = 1'b1;
               state_nx   = S_OUT_ACK;
            end
         end
         S_OUT_ACK: begin
            if (!bus.req_out) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign bus.ack_in  = (state == S_IN_ACK);
   assign bus.ack_out = (state == S_OUT_ACK);

   // Datapath: capture on accepted input, publish on consumer request, sticky clamp flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d1           <= '0;
         result       <= '0;
         bus.data_out <= '0;
         bus.sat_flag <= 1'b0;
      end else begin
         if (accept_in) begin
            result <= {sat(y0_w), sat(y1_w)};
            d1     <= bus.data_in_h1;
            if (y0_clamp || y1_clamp) bus.sat_flag <= 1'b1;
         end
         if (launch_out) bus.data_out <= result;
      end
   end
endmodule

// File: tb/tb_ffa_postproc_hs.sv
// tb/tb_ffa_postproc_hs.sv - scoreboard bench for ffa_postproc_hs
module tb_ffa_postproc_hs;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic [31:0] exp_q[$];

   ffa_postproc_hs_if #(.DWIDTH(16)) bus ();

   ffa_postproc_hs #(.NR_STAGES(32), .DWIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input int y0, input int y1);
      exp_q.push_back({y0[15:0], y1[15:0]});
   endtask

   // Monitor: each rising ack_out presents one pair to compare against the queue head.
   logic prev_ack_out;
   initial prev_ack_out = 1'b0;
   always @(negedge clk) begin
      logic [31:0] e;
      if (bus.ack_out === 1'b1 && prev_ack_out !== 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", bus.data_out, 32'hxxxx_xxxx);
         end else begin
            e = exp_q.pop_front();
            chk("data_out", bus.data_out, e);
         end
      end
      prev_ack_out = bus.ack_out;
   end

   task automatic wait_ack_in(input logic lvl, input string name);
      int n = 0;
      while (bus.ack_in !== lvl && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus.ack_in !== lvl) chk(name, 32'(bus.ack_in), 32'(lvl));
   endtask

   task automatic wait_ack_out(input logic lvl, input string name);
      int n = 0;
      while (bus.ack_out !== lvl && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (bus.ack_out !== lvl) chk(name, 32'(bus.ack_out), 32'(lvl));
   endtask

   task automatic drive_in(input int p0, input int p1, input int p01);
      bus.data_in_h0  = p0[15:0];
      bus.data_in_h1  = p1[15:0];
      bus.data_in_h01 = p01[15:0];
   endtask

   task automatic send(input int p0, input int p1, input int p01, input bit chk_lat);
      drive_in(p0, p1, p01);
      bus.req_in = 1'b1;
      @(negedge clk);
      if (chk_lat) chk("ack_in_latency1", 32'(bus.ack_in), 32'd1);
      wait_ack_in(1'b1, "ack_in_rise_timeout");
      bus.req_in = 1'b0;
      @(negedge clk);
      wait_ack_in(1'b0, "ack_in_fall_timeout");
   endtask

   task automatic get_out();
      bus.req_out = 1'b1;
      @(negedge clk);
      wait_ack_out(1'b1, "ack_out_rise_timeout");
      bus.req_out = 1'b0;
      @(negedge clk);
      wait_ack_out(1'b0, "ack_out_fall_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n;
      bit  early, seen, stayed;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.req_in  = 1'b0;
      bus.req_out = 1'b0;
      drive_in(0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_ack_in",   32'(bus.ack_in),   32'd0);
      chk("rst_ack_out",  32'(bus.ack_out),  32'd0);
      chk("rst_data_out", bus.data_out,      32'd0);
      chk("rst_sat_flag", 32'(bus.sat_flag), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // basic transfer and delay line
      push_exp(100, 30);
      send(100, 20, 150, 1'b1);
      get_out();
      push_exp(25, 28);
      send(5, 7, 40, 1'b0);
      get_out();
      chk("sat_clear_before", 32'(bus.sat_flag), 32'd0);

      // saturation
      push_exp(7, 0);
      send(0, 10000, 10000, 1'b0);
      get_out();
      push_exp(32767, -30000);
      send(30000, 0, 0, 1'b0);
      get_out();
      chk("sat_set", 32'(bus.sat_flag), 32'd1);
      push_exp(0, -32768);
      send(0, 0, -32768, 1'b0);
      get_out();
      chk("sat_sticky", 32'(bus.sat_flag), 32'd1);

      // backpressure: second input refused while the buffer is full
      push_exp(1, 0);
      send(1, 2, 3, 1'b0);
      push_exp(6, -3);
      drive_in(4, 5, 6);
      bus.req_in = 1'b1;
      stayed = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.ack_in !== 1'b0) stayed = 1'b0;
      end
      chk("backpressure_ack_in_low", 32'(stayed), 32'd1);
      get_out();
      wait_ack_in(1'b1, "bp_ack_in_rise_timeout");
      bus.req_in = 1'b0;
      @(negedge clk);
      wait_ack_in(1'b0, "bp_ack_in_fall_timeout");
      get_out();

      // ordering: req_out raised before req_in
      push_exp(15, 40);
      bus.req_out = 1'b1;
      @(negedge clk);
      drive_in(10, 20, 70);
      bus.req_in = 1'b1;
      early = 1'b0;
      seen  = 1'b0;
      n     = 0;
      while (n < 50) begin
         @(negedge clk);
         n++;
         if (bus.ack_out === 1'b1) early = 1'b1;
         if (bus.ack_in === 1'b1) begin
            seen = 1'b1;
            bus.req_in = 1'b0;
         end else if (seen) begin
            break;
         end
      end
      chk("order_no_early_ack_out", 32'(early), 32'd0);
      chk("order_ack_in_cycle", 32'(seen && bus.ack_in === 1'b0), 32'd1);
      wait_ack_out(1'b1, "order_ack_out_timeout");
      stayed = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.ack_out !== 1'b1) stayed = 1'b0;
      end
      chk("order_ack_out_held", 32'(stayed), 32'd1);
      bus.req_out = 1'b0;
      @(negedge clk);
      chk("order_ack_out_fall", 32'(bus.ack_out), 32'd0);
      chk("data_out_kept", bus.data_out, {16'd15, 16'd40});

      // asynchronous reset in the middle of S_OUT_ACK
      push_exp(27, -6);
      send(7, 8, 9, 1'b0);
      bus.req_out = 1'b1;
      @(negedge clk);
      wait_ack_out(1'b1, "pre_rst_ack_out_timeout");
      #2 rst = 1'b1;
      #1;
      chk("arst_ack_in",   32'(bus.ack_in),   32'd0);
      chk("arst_ack_out",  32'(bus.ack_out),  32'd0);
      chk("arst_data_out", bus.data_out,      32'd0);
      chk("arst_sat_flag", 32'(bus.sat_flag), 32'd0);
      bus.req_out = 1'b0;
      drive_in(1, 2, 4);
      bus.req_in = 1'b1;
      push_exp(1, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wait_ack_in(1'b1, "post_rst_ack_in_timeout");
      bus.req_in = 1'b0;
      @(negedge clk);
      wait_ack_in(1'b0, "post_rst_ack_in_fall_timeout");
      get_out();

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
